// File: rtl/cnt_bits_selector_pkg.sv
// Shared enable and active-level constants for the bit-count-and-select stage.
package cnt_bits_selector_pkg;

  localparam int ENABLE  = 1;
  localparam int DISABLE = 0;
  localparam int HIGH    = 1;
  localparam int LOW     = 0;

endpackage

// File: rtl/cnt_bits_selector_cnt_bits.sv
// Combinational population count of bits equal to ACT, built as a recursive
// halving adder tree. The output is wide enough to hold IN itself.
module cnt_bits #(
  parameter int IN  = 8,
  parameter int ACT = 1
) (
  input  logic [IN-1:0]       in,
  output logic [$clog2(IN):0] cnt
);

  localparam int  W     = $clog2(IN) + 1;
  localparam logic ACT_B = 1'(ACT);

  if (IN == 1) begin : g_leaf
    assign cnt = (in[0] == ACT_B);
  end else begin : g_split
    localparam int LO = IN / 2;
    localparam int HI = IN - LO;

    logic [$clog2(LO):0] w_lo;
    logic [$clog2(HI):0] w_hi;

    cnt_bits #(.IN(LO), .ACT(ACT)) u_lo (.in(in[LO-1:0]),  .cnt(w_lo));
    cnt_bits #(.IN(HI), .ACT(ACT)) u_hi (.in(in[IN-1:LO]), .cnt(w_hi));

    assign cnt = W'(w_lo) + W'(w_hi);
  end

endmodule

// File: rtl/cnt_bits_selector_selector.sv
// Combinational winner selection: lowest-index priority over a bitmap, or a
// decoded binary index, followed by a one-hot AND-OR data mux.
module selector
  import cnt_bits_selector_pkg::*;
#(
  parameter int BIT_MAP = ENABLE,
  parameter int DATA    = 32,
  parameter int IN      = 8,
  parameter int ACT     = HIGH,
  parameter int NUM     = $clog2(IN),
  parameter int SW      = (BIT_MAP == ENABLE) ? IN : NUM
) (
  input  logic [IN-1:0][DATA-1:0] in,
  input  logic [SW-1:0]           sel,
  output logic                    valid,
  output logic [NUM-1:0]          pos,
  output logic [DATA-1:0]         out
);

  localparam logic ACT_B = 1'(ACT);

  logic [IN-1:0] w_grant;

  if (BIT_MAP == ENABLE) begin : g_bitmap
    logic [IN-1:0] w_act;
    // Two's-complement trick isolates the lowest set bit as a one-hot grant.
    assign w_act   = ACT_B ? sel : ~sel;
    assign w_grant = w_act & (~w_act + IN'(1));
  end else begin : g_index
    // Codes at or above IN match no entry, leaving the grant empty.
    always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_grant = '0;
      for (int i = 0; i < IN; i++) w_grant[i] = (sel == NUM'(i));
    end
  end

  always_comb begin
    pos = '0;
    out = '0;
    for (int i = 0; i < IN; i++) begin
      if (w_grant[i]) pos = pos | NUM'(i);
      out = out | (in[i] & {DATA{w_grant[i]}});
    end
    valid = (|w_grant) ? ACT_B : ~ACT_B;
  end

endmodule

// File: rtl/cnt_bits_selector.sv
// Registered bit-count-and-select stage: popcount plus winner selection,
// all four results captured together for one-cycle latency.
module cnt_bits_selector
  import cnt_bits_selector_pkg::*;
#(
  parameter int DATA    = 32,
  parameter int IN      = 8,
  parameter int ACT     = HIGH,
  parameter int BIT_MAP = ENABLE,
  parameter int NUM     = $clog2(IN),
  parameter int SW      = (BIT_MAP == ENABLE) ? IN : NUM
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic [IN-1:0][DATA-1:0] in,
  input  logic [SW-1:0]           sel,
  output logic [NUM:0]            cnt,
  output logic                    valid,
  output logic [NUM-1:0]          pos,
  output logic [DATA-1:0]         out
);

  localparam logic ACT_B = 1'(ACT);

  logic [NUM:0]     w_cnt;
  logic             w_valid;
  logic [NUM-1:0]   w_pos;
  logic [DATA-1:0]  w_out;

  if (BIT_MAP == ENABLE) begin : g_count
    cnt_bits #(.IN(IN), .ACT(ACT)) u_cnt_bits (.in(sel), .cnt(w_cnt));
  end else begin : g_no_count
    assign w_cnt = '0;
  end

  selector #(
    .BIT_MAP (BIT_MAP),
    .DATA    (DATA),
    .IN      (IN),
    .ACT     (ACT)
  ) u_selector (
    .in    (in),
    .sel   (sel),
    .valid (w_valid),
    .pos   (w_pos),
    .out   (w_out)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt   <= '0;
      valid <= ~ACT_B;
      pos   <= '0;
      out   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all four outputs sampled from the same edge.
      cnt   <= w_cnt;
      valid <= w_valid;
      pos   <= w_pos;
      out   <= w_out;
    end
  end

endmodule

// File: tb/tb_cnt_bits_selector.sv
// Directed and short random checks of cnt_bits_selector in active-high bitmap,
// active-low bitmap and index (IN = 6) configurations.
module tb_cnt_bits_selector;
  import cnt_bits_selector_pkg::*;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic reset_ = 1'b1;

  logic [7:0][31:0] d8;
  logic [5:0][31:0] d6;
  logic [7:0] sel_hi, sel_lo;
  logic [2:0] sel_ix;

  logic [3:0]  hi_cnt, lo_cnt, ix_cnt;
  logic        hi_valid, lo_valid, ix_valid;
  logic [2:0]  hi_pos, lo_pos, ix_pos;
  logic [31:0] hi_out, lo_out, ix_out;

  logic [39:0] hi_all, lo_all, ix_all;
  assign hi_all = {hi_cnt, hi_valid, hi_pos, hi_out};
  assign lo_all = {lo_cnt, lo_valid, lo_pos, lo_out};
  assign ix_all = {ix_cnt, ix_valid, ix_pos, ix_out};

  localparam logic [39:0] RST_HI = {4'd0, 1'b0, 3'd0, 32'd0};
  localparam logic [39:0] RST_LO = {4'd0, 1'b1, 3'd0, 32'd0};

  always #5 clk = ~clk;

  cnt_bits_selector #(.DATA(32), .IN(8), .ACT(HIGH), .BIT_MAP(ENABLE)) u_hi (
    .clk(clk), .reset_(reset_), .in(d8), .sel(sel_hi),
    .cnt(hi_cnt), .valid(hi_valid), .pos(hi_pos), .out(hi_out));

  cnt_bits_selector #(.DATA(32), .IN(8), .ACT(LOW), .BIT_MAP(ENABLE)) u_lo (
    .clk(clk), .reset_(reset_), .in(d8), .sel(sel_lo),
    .cnt(lo_cnt), .valid(lo_valid), .pos(lo_pos), .out(lo_out));

  cnt_bits_selector #(.DATA(32), .IN(6), .ACT(HIGH), .BIT_MAP(DISABLE)) u_ix (
    .clk(clk), .reset_(reset_), .in(d6), .sel(sel_ix),
    .cnt(ix_cnt), .valid(ix_valid), .pos(ix_pos), .out(ix_out));

  // Reference: {cnt, valid, pos, out} for an 8-entry bitmap at level act.
  function automatic logic [39:0] model(input logic [7:0][31:0] d,
                                        input logic [7:0] s, input logic act);
    logic [3:0]  c;
    logic        v;
    logic [2:0]  p;
    logic [31:0] o;
    logic        found;
    c = 0; v = ~act; p = 0; o = 0; found = 0;
    for (int i = 0; i < 8; i++) begin
      if (s[i] == act) begin
        c = c + 1;
        if (!found) begin
          found = 1; v = act; p = 3'(i); o = d[i];
        end
      end
    end
    return {c, v, p, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) d8[i] = $urandom;
    for (int i = 0; i < 6; i++) d6[i] = $urandom;
    sel_hi = 8'h5A; sel_lo = 8'hA5; sel_ix = 3'd2;
    #1 reset_ = 1'b0;
    repeat (3) tick();
    checks++;
    if (hi_all !== RST_HI) begin errors++; $display("FAIL reset_hi got %h exp %h", hi_all, RST_HI); end
    checks++;
    if (lo_all !== RST_LO) begin errors++; $display("FAIL reset_lo got %h exp %h", lo_all, RST_LO); end
    checks++;
    if (ix_all !== RST_HI) begin errors++; $display("FAIL reset_ix got %h exp %h", ix_all, RST_HI); end
    @(negedge clk);
    reset_ = 1'b1;
    #1;
    checks++;
    if (hi_all !== RST_HI) begin errors++; $display("FAIL release_hold got %h exp %h", hi_all, RST_HI); end
  endtask

  task automatic test_bitmap_high();
    logic [39:0] exp;
    for (int i = 0; i < 8; i++) d8[i] = 32'hA0 + i;
    sel_hi = 8'b0010_1100;
    tick();
    exp = {4'd3, 1'b1, 3'd2, 32'hA2};
    checks++;
    if (hi_all !== exp) begin errors++; $display("FAIL bmp_mixed got %h exp %h", hi_all, exp); end
    sel_hi = 8'hFF;
    tick();
    exp = {4'd8, 1'b1, 3'd0, 32'hA0};
    checks++;
    if (hi_all !== exp) begin errors++; $display("FAIL bmp_all got %h exp %h", hi_all, exp); end
    sel_hi = 8'h00;
    tick();
    checks++;
    if (hi_all !== RST_HI) begin errors++; $display("FAIL bmp_none got %h exp %h", hi_all, RST_HI); end
    sel_hi = 8'h80;
    tick();
    exp = {4'd1, 1'b1, 3'd7, 32'hA7};
    checks++;
    if (hi_all !== exp) begin errors++; $display("FAIL bmp_top got %h exp %h", hi_all, exp); end
  endtask

  task automatic test_bitmap_low();
    logic [39:0] exp;
    sel_lo = 8'b1111_0111;
    tick();
    exp = {4'd1, 1'b0, 3'd3, 32'hA3};
    checks++;
    if (lo_all !== exp) begin errors++; $display("FAIL low_single got %h exp %h", lo_all, exp); end
    sel_lo = 8'hFF;
    tick();
    checks++;
    if (lo_all !== RST_LO) begin errors++; $display("FAIL low_none got %h exp %h", lo_all, RST_LO); end
    sel_lo = 8'h00;
    tick();
    exp = {4'd8, 1'b0, 3'd0, 32'hA0};
    checks++;
    if (lo_all !== exp) begin errors++; $display("FAIL low_all got %h exp %h", lo_all, exp); end
  endtask

  task automatic test_index();
    logic [2:0]  sels [4] = '{3'd5, 3'd7, 3'd0, 3'd6};
    logic [39:0] exps [4] = '{{4'd0, 1'b1, 3'd5, 32'hB5}, 40'd0,
                              {4'd0, 1'b1, 3'd0, 32'hB0}, 40'd0};
    for (int i = 0; i < 6; i++) d6[i] = 32'hB0 + i;
    for (int k = 0; k < 4; k++) begin
      sel_ix = sels[k];
      tick();
      checks++;
      if (ix_all !== exps[k])
        begin errors++; $display("FAIL index_sel%0d got %h exp %h", sels[k], ix_all, exps[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp_hi, exp_lo;
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int i = 0; i < 8; i++) d8[i] = $urandom;
      sel_hi = 8'($urandom & $urandom);
      sel_lo = 8'($urandom | $urandom);
      exp_hi = model(d8, sel_hi, 1'b1);
      exp_lo = model(d8, sel_lo, 1'b0);
      tick();
      checks++;
      if (hi_all !== exp_hi) begin errors++; $display("FAIL b2b_hi c%0d got %h exp %h", cyc, hi_all, exp_hi); end
      checks++;
      if (lo_all !== exp_lo) begin errors++; $display("FAIL b2b_lo c%0d got %h exp %h", cyc, lo_all, exp_lo); end
      if (cyc == 10) begin
        reset_ = 1'b0;
        #1;
        checks++;
        if (hi_all !== RST_HI) begin errors++; $display("FAIL async_rst_hi got %h exp %h", hi_all, RST_HI); end
        checks++;
        if (lo_all !== RST_LO) begin errors++; $display("FAIL async_rst_lo got %h exp %h", lo_all, RST_LO); end
        #2 reset_ = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_bitmap_high();
    test_bitmap_low();
    test_index();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
